// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared mode encodings and buffer depth for the immediate
//               extension pipeline.
// Revision    : 1.0  initial release
// ============================================================================
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    localparam int BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational IN_W -> OUT_W immediate extender supporting
//               sign, zero, upper-load and branch-offset modes.
// Revision    : 1.0  initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        ext = w_sext;
        case (mode)
            MODE_SIGN:   ext = w_sext;
            MODE_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
            // Word-aligned branch offset: the top two sign bits fall off.
            MODE_BRANCH: ext = {w_sext[OUT_W-3:0], 2'b00};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Immediate extender followed by a 2-entry valid/ready output
//               buffer. Optional macro IMM_EXT_TAG_EN adds a per-entry tag.
// Revision    : 1.0  initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   imm,
    input  logic [1:0]        mode,
`ifdef IMM_EXT_TAG_EN
    input  logic [TAG_W-1:0]  in_tag,
    output logic [TAG_W-1:0]  out_tag,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_imm
);

    localparam int c_ptr_w = $clog2(BUF_DEPTH);
    localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);

    if (IN_W < 2 || OUT_W < IN_W + 2 || TAG_W < 1) begin : g_bad_params
        $error("imm_extend_pipe: illegal IN_W/OUT_W/TAG_W combination");
    end

    logic [OUT_W-1:0]   w_ext;
    logic               w_push;
    logic               w_pop;
    logic [OUT_W-1:0]   r_data [BUF_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (imm),
        .mode (mode),
        .ext  (w_ext)
    );

    // Handshake flags depend only on the registered count.
    assign in_ready  = (r_count != c_cnt_w'(BUF_DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_imm   = r_data[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_ext;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IMM_EXT_TAG_EN
    logic [TAG_W-1:0] r_tag [BUF_DEPTH];

    assign out_tag = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else if (w_push) begin
            r_tag[r_wr_ptr] <= in_tag;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Directed scoreboard bench for imm_extend_pipe (plus a 12-bit
//               instance); tag checks active when IMM_EXT_TAG_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] out_imm;
`ifdef IMM_EXT_TAG_EN
    logic [4:0]  in_tag, out_tag;
`endif

    logic        v12, rdy12, ov12, or12;
    logic [11:0] imm12;
    logic [1:0]  mode12;
    logic [31:0] o12;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .mode      (mode),
`ifdef IMM_EXT_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm)
    );

`ifdef IMM_EXT_TAG_EN
    logic [4:0] tag12_in, tag12_out;
`endif

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut12 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v12),
        .in_ready  (rdy12),
        .imm       (imm12),
        .mode      (mode12),
`ifdef IMM_EXT_TAG_EN
        .in_tag    (tag12_in),
        .out_tag   (tag12_out),
`endif
        .out_valid (ov12),
        .out_ready (or12),
        .out_imm   (o12)
    );

    typedef struct packed {
        logic [31:0] val;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference extension written arithmetically, independent of the RTL.
    function automatic logic [31:0] model(input logic [15:0] v, input logic [1:0] m, input int w);
        logic [31:0] mask, raw, sx;
        mask = (32'd1 << w) - 32'd1;
        raw  = {16'h0, v} & mask;
        sx   = raw;
        if (raw[w-1]) sx = raw | ~mask;
        case (m)
            2'd0:    return sx;
            2'd1:    return raw;
            2'd2:    return raw << (32 - w);
            default: return sx << 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Settle inputs, score the transfers of the coming edge, then advance.
    task automatic step(input string name);
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check({name, " unexpected out_valid"}, {31'h0, out_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                check({name, " out_imm"}, out_imm, e.val);
`ifdef IMM_EXT_TAG_EN
                check({name, " out_tag"}, {27'h0, out_tag}, {27'h0, e.tag});
`endif
            end
        end
        if (in_valid && in_ready) begin
            e.val = model(imm, mode, 16);
`ifdef IMM_EXT_TAG_EN
            e.tag = in_tag;
`else
            e.tag = 5'd0;
`endif
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; imm = '0; mode = '0;
        v12 = 1'b0; or12 = 1'b0; imm12 = '0; mode12 = '0;
`ifdef IMM_EXT_TAG_EN
        in_tag = '0; tag12_in = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst in_ready", {31'h0, in_ready}, 32'h1);
        check("rst out_valid", {31'h0, out_valid}, 32'h0);
        check("rst out_imm", out_imm, 32'h0);
`ifdef IMM_EXT_TAG_EN
        check("rst out_tag", {27'h0, out_tag}, 32'h0);
`endif

        // Mode sweep with free-flowing consumer
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm       = 16'h8001;
        for (int m = 0; m < 4; m++) begin
            mode = m[1:0];
            step("sweep");
            check("sweep out_valid", {31'h0, out_valid}, 32'h1);
        end
        in_valid = 1'b0;
        step("sweep drain");
        check("sweep empty", {31'h0, out_valid}, 32'h0);

        // Back-pressure: fill, hold a third item, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'd1;
        imm       = 16'h0005; step("bp");
        imm       = 16'h0006; step("bp");
        check("bp full in_ready", {31'h0, in_ready}, 32'h0);
        check("bp full out_valid", {31'h0, out_valid}, 32'h1);
        imm       = 16'h0007; step("bp held");
        check("bp held in_ready", {31'h0, in_ready}, 32'h0);
        check("bp head", out_imm, 32'h0000_0005);
        out_ready = 1'b1;
        step("bp release");
        check("bp reopen in_ready", {31'h0, in_ready}, 32'h1);
        step("bp third");
        in_valid  = 1'b0;
        step("bp drain");
        check("bp empty", {31'h0, out_valid}, 32'h0);
        check("bp sb drained", 32'(sb.size()), 32'h0);

        // Streaming: simultaneous push/pop at count 1
        mode     = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imm = 16'h8000 ^ 16'(i * 16'h1357);
            step("stream");
            check("stream in_ready", {31'h0, in_ready}, 32'h1);
            check("stream out_valid", {31'h0, out_valid}, 32'h1);
        end
        in_valid = 1'b0;
        step("stream drain");
        check("stream empty", {31'h0, out_valid}, 32'h0);
        check("stream sb drained", 32'(sb.size()), 32'h0);

        // Reset with two entries buffered and a push/pop pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm       = 16'h1111; step("rstmid fill");
        imm       = 16'h2222; step("rstmid fill");
        reset     = 1'b1;
        out_ready = 1'b1;
        imm       = 16'h3333;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("rstmid out_valid", {31'h0, out_valid}, 32'h0);
        check("rstmid out_imm", out_imm, 32'h0);
        check("rstmid in_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        imm      = 16'h4444;
        step("rstmid push");
        in_valid = 1'b0;
        step("rstmid drain");
        check("rstmid empty", {31'h0, out_valid}, 32'h0);

        // 12-bit instance
        v12 = 1'b1; or12 = 1'b1; imm12 = 12'h800; mode12 = 2'd0;
        @(posedge clk);
        #1;
        check("w12 valid", {31'h0, ov12}, 32'h1);
        check("w12 sign", o12, model({4'h0, imm12}, 2'd0, 12));
        mode12 = 2'd3;
        @(posedge clk);
        #1;
        v12 = 1'b0;
        check("w12 branch", o12, model({4'h0, imm12}, 2'd3, 12));

`ifdef IMM_EXT_TAG_EN
        // Tag alignment under back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'd0;
        imm = 16'h0010; in_tag = 5'd7;  step("tag");
        imm = 16'hFFFF; in_tag = 5'd31; step("tag");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step("tag drain");
        step("tag drain");
        check("tag sb drained", 32'(sb.size()), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
